io_timer_periph: RTL

- Memory-mapped timer and GPIO peripheral on the core's data bus (daddr/ddata_w/MemRead/MemWrite), alongside the data RAM.
- Claims a 32-byte window at BASE_ADDR. Top level muxes its read data into ddata_r when io_hit=1.
- Provides a prescaled 32-bit up-counter with compare match, a level interrupt, a GPIO output register and synchronized GPIO inputs.

---
 rtl/io_timer_periph.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/io_timer_periph.sv
// io_timer_periph: memory-mapped prescaled timer with compare/IRQ plus GPIO,
// decoded from a 32-byte window on the core data bus.
module io_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [31:0]       daddr,
  input  logic [31:0]       ddata_w,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic              io_hit,
  output logic [31:0]       io_rdata,
  output logic              irq,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in
);

  localparam int unsigned DW   = 32;
  localparam int unsigned PW   = 16;
  localparam int unsigned CW   = 3;
  localparam int unsigned OFFW = 3;

  localparam logic [OFFW-1:0] OFF_CTRL     = 3'd0;
  localparam logic [OFFW-1:0] OFF_PRESC    = 3'd1;
  localparam logic [OFFW-1:0] OFF_CMP      = 3'd2;
  localparam logic [OFFW-1:0] OFF_COUNT    = 3'd3;
  localparam logic [OFFW-1:0] OFF_STATUS   = 3'd4;
  localparam logic [OFFW-1:0] OFF_GPIO_OUT = 3'd5;
  localparam logic [OFFW-1:0] OFF_GPIO_IN  = 3'd6;

  // CTRL bit positions
  localparam int unsigned B_EN     = 0;
  localparam int unsigned B_RELOAD = 1;
  localparam int unsigned B_IRQ_EN = 2;

  logic [CW-1:0]     ctrl_q,     ctrl_d;
  logic [PW-1:0]     presc_q,    presc_d;
  logic [DW-1:0]     cmp_q,      cmp_d;
  logic [DW-1:0]     count_q,    count_d;
  logic              match_q,    match_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q,    sync1_d;
  logic [GPIO_W-1:0] sync2_q,    sync2_d;
  logic [PW-1:0]     pcnt_q,     pcnt_d;
  logic              irq_q,      irq_d;

  logic [OFFW-1:0] offset;
  logic            wr_en;
  logic            wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status, wr_gpio;
  logic            tick;
  logic            match_set;
  logic [DW-1:0]   rdata_sel;
  logic            unused_addr_bits;

  // Byte lane bits are don't-care: every access is a full word.
  assign unused_addr_bits = ^daddr[1:0];

  // Address decode and per-register write strobes.
  always_comb begin
    io_hit    = (daddr[31:5] == BASE_ADDR[31:5]);
    offset    = daddr[4:2];
    wr_en     = io_hit & MemWrite;
    wr_ctrl   = wr_en && (offset == OFF_CTRL);
    wr_presc  = wr_en && (offset == OFF_PRESC);
    wr_cmp    = wr_en && (offset == OFF_CMP);
    wr_count  = wr_en && (offset == OFF_COUNT);
    wr_status = wr_en && (offset == OFF_STATUS);
    wr_gpio   = wr_en && (offset == OFF_GPIO_OUT);
  end

  // Next-state: register writes, prescaler, counter/compare, MATCH and irq.
  always_comb begin
    ctrl_d     = ctrl_q;
    presc_d    = presc_q;
    cmp_d      = cmp_q;
    count_d    = count_q;
    match_d    = match_q;
    gpio_out_d = gpio_out_q;
    pcnt_d     = pcnt_q;
    match_set  = 1'b0;
    sync1_d    = gpio_in;
    sync2_d    = sync1_q;

    tick = ctrl_q[B_EN] && (pcnt_q == presc_q);

    if (wr_ctrl)  ctrl_d     = ddata_w[CW-1:0];
    if (wr_presc) presc_d    = ddata_w[PW-1:0];
    if (wr_cmp)   cmp_d      = ddata_w;
    if (wr_gpio)  gpio_out_d = ddata_w[GPIO_W-1:0];

    // Prescaler idles at zero while disabled; any CTRL/PRESC write restarts it.
    if (!ctrl_q[B_EN] || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
    if (wr_ctrl || wr_presc) pcnt_d = '0;

    // Counter advances on tick; a compare hit optionally reloads to zero.
    if (tick) begin
      if (count_q == cmp_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[B_RELOAD] ? '0 : count_q + DW'(1);
      end else begin
        count_d   = count_q + DW'(1);
      end
    end
    // A CPU write to COUNT wins over the tick and suppresses that cycle's match.
    if (wr_count) begin
      count_d   = ddata_w;
      match_set = 1'b0;
    end

    // W1C clear loses to a same-cycle match.
    if (wr_status && ddata_w[0]) match_d = 1'b0;
    if (match_set)               match_d = 1'b1;

    irq_d = match_d & ctrl_d[B_IRQ_EN];
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_q     <= '0;
      presc_q    <= '0;
      cmp_q      <= '0;
      count_q    <= '0;
      match_q    <= 1'b0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      cmp_q      <= cmp_d;
      count_q    <= count_d;
      match_q    <= match_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
    end
  end

  // Read mux; zero outside the window or when no read is strobed.
  always_comb begin
    rdata_sel = '0;
    case (offset)
      OFF_CTRL:     rdata_sel = DW'(ctrl_q);
      OFF_PRESC:    rdata_sel = DW'(presc_q);
      OFF_CMP:      rdata_sel = cmp_q;
      OFF_COUNT:    rdata_sel = count_q;
      OFF_STATUS:   rdata_sel = DW'(match_q);
      OFF_GPIO_OUT: rdata_sel = DW'(gpio_out_q);
      OFF_GPIO_IN:  rdata_sel = DW'(sync2_q);
      default:      rdata_sel = '0;
    endcase
    io_rdata = (io_hit && MemRead) ? rdata_sel : '0;
  end

  assign irq      = irq_q;
  assign gpio_out = gpio_out_q;

endmodule
